// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b: one full-subtractor cell stepped LSB-first over WIDTH RUN cycles.
// Flags and difference are registered on the last RUN edge and hold until the next completion.
module serial_sub_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             bo_q, bo_d, ov_q, ov_d, zero_q, zero_d;

   logic             cell_d, cell_bout, last_bit;
   logic [WIDTH-1:0] sr_next;

   always_comb begin
      cell_d    = sa_q[0] ^ sb_q[0] ^ br_q;
      cell_bout = (~(sa_q[0] ^ sb_q[0]) & br_q) | (~sa_q[0] & sb_q[0]);
      sr_next   = sr_q >> 1;
      sr_next[WIDTH-1] = cell_d;
      last_bit  = (cnt_q == CW'(WIDTH - 1));

      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      diff_d  = diff_q;
      bo_d    = bo_q;
      ov_d    = ov_q;
      zero_d  = zero_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               sa_d    = a;
               sb_d    = b;
               sr_d    = '0;
               cnt_d   = '0;
               br_d    = 1'b0;
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            sr_d  = sr_next;
            br_d  = cell_bout;
            cnt_d = cnt_q + CW'(1);
            // Result registers only move on the final bit so they stay stable while running.
            if (last_bit) begin
               state_d = DONE;
               diff_d  = sr_next;
               bo_d    = cell_bout;
               zero_d  = (sr_next == '0);
               ov_d    = (a_msb_q ^ b_msb_q) & (sr_next[WIDTH-1] ^ a_msb_q);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bo_q    <= 1'b0;
         ov_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bo_q    <= bo_d;
         ov_q    <= ov_d;
         zero_q  <= zero_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign diff       = diff_q;
   assign borrow_out = bo_q;
   assign overflow   = ov_q;
   assign zero       = zero_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboarded bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, start1 = 1'b0;
   logic [7:0] a_i = '0, b_i = '0;
   logic       a1_i = 1'b0, b1_i = 1'b0;

   logic       busy, done, borrow_out, overflow, zero;
   logic [7:0] diff;
   logic       busy1, done1, diff1, bo1, ov1, z1;

   int checks = 0;
   int errors = 0;

   logic [10:0] exp_q[$];
   logic [3:0]  exp1_q[$];
   logic [10:0] last_res = '0;

   always #5 clk = ~clk;

   serial_sub_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a_i), .b(b_i),
      .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
      .overflow(overflow), .zero(zero)
   );

   serial_sub_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1_i), .b(b1_i),
      .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1),
      .overflow(ov1), .zero(z1)
   );

   // {diff, borrow, overflow, zero}
   function automatic logic [10:0] model8(input logic [7:0] x, input logic [7:0] y);
      int sd;
      logic [7:0] dv;
      logic bo, ov, z;
      dv = x - y;
      sd = int'($signed(x)) - int'($signed(y));
      ov = (sd > 127) || (sd < -128);
      bo = (x < y);
      z  = (dv == 8'h00);
      return {dv, bo, ov, z};
   endfunction

   function automatic logic [3:0] model1(input logic x, input logic y);
      int sx, sy, sd;
      logic dv, bo, ov, z;
      sx = x ? -1 : 0;
      sy = y ? -1 : 0;
      sd = sx - sy;
      dv = x ^ y;
      bo = ~x & y;
      ov = (sd > 0) || (sd < -1);
      z  = ~dv;
      return {dv, bo, ov, z};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, diff, borrow_out, overflow, zero} !== 13'h0) begin
         errors++;
         $display("FAIL reset8: got %h want 0", {busy, done, diff, borrow_out, overflow, zero});
      end
      checks++;
      if ({busy1, done1, diff1, bo1, ov1, z1} !== 6'h0) begin
         errors++;
         $display("FAIL reset1: got %h want 0", {busy1, done1, diff1, bo1, ov1, z1});
      end
      rst_n = 1'b1;
      last_res = '0;
      @(negedge clk);
   endtask

   task automatic test_run_op(input logic [7:0] x, input logic [7:0] y, input bit mid_start);
      int lat, bcnt;
      bit hold_bad;
      logic [10:0] got, exp;
      @(negedge clk);
      start = 1'b1; a_i = x; b_i = y;
      exp_q.push_back(model8(x, y));
      @(negedge clk);
      start = 1'b0; a_i = ~x; b_i = 8'($urandom);
      lat = 1; bcnt = 0; hold_bad = 0;
      while (!done && lat < 40) begin
         if (busy) bcnt++;
         if ({diff, borrow_out, overflow, zero} !== last_res) hold_bad = 1;
         start = mid_start && (lat == 3);
         if (start) begin a_i = 8'hFF; b_i = 8'h00; end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      checks++;
      if (lat !== 9) begin errors++; $display("FAIL latency: got %0d want 9", lat); end
      checks++;
      if (bcnt !== 8) begin errors++; $display("FAIL busy_cycles: got %0d want 8", bcnt); end
      checks++;
      if (hold_bad) begin errors++; $display("FAIL result_hold: outputs changed during RUN, want %h", last_res); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL busy_in_done: got %b want 0", busy); end
      got = {diff, borrow_out, overflow, zero};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL result %h-%h: got diff=%h bo=%b ov=%b z=%b want diff=%h bo=%b ov=%b z=%b",
                  x, y, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
      end
      last_res = exp;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [10:0] got, exp;
      @(negedge clk);
      start = 1'b1; a_i = 8'h33; b_i = 8'h44;
      exp_q.push_back(model8(8'h33, 8'h44));
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 40);
      got = {diff, borrow_out, overflow, zero};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_first: got %h want %h", got, exp); end
      a_i = 8'h7F; b_i = 8'h80;
      exp_q.push_back(model8(8'h7F, 8'h80));
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 40);
      checks++;
      if (n !== 9) begin errors++; $display("FAIL b2b_gap: got %0d want 9", n); end
      got = {diff, borrow_out, overflow, zero};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_second: got %h want %h", got, exp); end
      start = 1'b0;
      last_res = exp;
      @(negedge clk);
      checks++;
      if ({done, busy} !== 2'b00) begin errors++; $display("FAIL b2b_stop: got done/busy=%b want 00", {done, busy}); end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      start = 1'b1; a_i = 8'hC3; b_i = 8'h12;
      exp_q.push_back(model8(8'hC3, 8'h12));
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, diff, borrow_out, overflow, zero} !== 13'h0) begin
         errors++;
         $display("FAIL async_reset: got %h want 0", {busy, done, diff, borrow_out, overflow, zero});
      end
      exp_q.delete();
      last_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin errors++; $display("FAIL post_reset_idle: got %b want 00", {busy, done}); end
      test_run_op(8'h10, 8'h01, 0);
   endtask

   task automatic test_width1();
      int n;
      logic [3:0] got, exp;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start1 = 1'b1; a1_i = i[1]; b1_i = i[0];
         exp1_q.push_back(model1(i[1], i[0]));
         @(negedge clk);
         start1 = 1'b0;
         n = 1;
         checks++;
         if (busy1 !== 1'b1) begin errors++; $display("FAIL w1_busy: got %b want 1", busy1); end
         while (!done1 && n < 10) begin @(negedge clk); n++; end
         checks++;
         if (n !== 2) begin errors++; $display("FAIL w1_latency: got %0d want 2", n); end
         got = {diff1, bo1, ov1, z1};
         exp = exp1_q.pop_front();
         checks++;
         if (got !== exp) begin errors++; $display("FAIL w1_result a=%0d b=%0d: got %b want %b", i[1], i[0], got, exp); end
      end
   endtask

   initial begin
      test_reset();
      test_run_op(8'h5A, 8'h3C, 0);
      test_run_op(8'h00, 8'h01, 0);
      test_run_op(8'h80, 8'h01, 0);
      test_run_op(8'hA5, 8'hA5, 0);
      test_run_op(8'h01, 8'h80, 1);
      test_back_to_back();
      test_reset_mid_run();
      test_width1();
      repeat (1000) test_run_op(8'($urandom), 8'($urandom), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
